// File: rtl/servo_cw_ramp.sv
// Rate-limited compare-word stage: slews PWM_CW toward a handshaken target by at most STEP per PWM frame.
// Optional target clamping to [CW_MIN, CW_MAX] is enabled by defining SERVO_CW_RAMP_CLAMP_EN.
module servo_cw_ramp #(
  parameter int unsigned PERIOD  = 62500,
  parameter int unsigned STEP    = 25,
  parameter int unsigned INIT_CW = 4688,
  parameter int unsigned CW_MIN  = 3125,
  parameter int unsigned CW_MAX  = 6250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] target_cw,
  input  logic        target_valid,
  output logic        target_ready,
  output logic [15:0] PWM_CW,
  output logic        frame_tick,
  output logic        busy,
  output logic        clamp_hit
);

`ifdef SERVO_CW_RAMP_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [15:0] PERIOD_W  = 16'(PERIOD);
  localparam logic [16:0] STEP_W    = 17'(STEP);
  localparam logic [15:0] INIT_W    = 16'(INIT_CW);
  localparam logic [15:0] CW_MIN_W  = 16'(CW_MIN);
  localparam logic [15:0] CW_MAX_W  = 16'(CW_MAX);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] frame_cnt;
  logic [15:0] pend_cw;
  logic        pend_valid;
  logic [15:0] target_reg;
  logic        accept;
  logic [15:0] eff;
  logic [15:0] next_cw;
  logic [16:0] diff;
  logic [15:0] clamped_cw;
  logic [15:0] stored_cw;

  assign target_ready = !pend_valid;
  assign accept       = target_valid && !pend_valid;
  assign eff          = pend_valid ? pend_cw : target_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= 16'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_cnt  <= (frame_cnt == PERIOD_W) ? 16'd0 : frame_cnt + 16'd1;
      frame_tick <= (frame_cnt == PERIOD_W);
    end
  end

  always_comb begin
    clamped_cw = target_cw;
    if (target_cw < CW_MIN_W)
      clamped_cw = CW_MIN_W;
    else if (target_cw > CW_MAX_W)
      clamped_cw = CW_MAX_W;
  end

  assign stored_cw = CLAMP_EN ? clamped_cw : target_cw;

  // Differences are taken 17 bits wide so neither direction can wrap.
  always_comb begin
    diff    = 17'd0;
    next_cw = PWM_CW;
    if (STEP == 0) begin
      next_cw = eff;
    end else if (eff > PWM_CW) begin
      diff    = {1'b0, eff} - {1'b0, PWM_CW};
      next_cw = (diff > STEP_W) ? PWM_CW + STEP_W[15:0] : eff;
    end else if (eff < PWM_CW) begin
      diff    = {1'b0, PWM_CW} - {1'b0, eff};
      next_cw = (diff > STEP_W) ? PWM_CW - STEP_W[15:0] : eff;
    end
  end

  // An accept coinciding with the tick lands in pend and is applied on the following tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cw    <= INIT_W;
      pend_valid <= 1'b0;
      target_reg <= INIT_W;
      PWM_CW     <= INIT_W;
      clamp_hit  <= 1'b0;
    end else begin
      clamp_hit <= CLAMP_EN && accept && (clamped_cw != target_cw);
      if (accept) begin
        pend_cw    <= stored_cw;
        pend_valid <= 1'b1;
      end else if (frame_tick) begin
        pend_valid <= 1'b0;
      end
      if (frame_tick) begin
        target_reg <= eff;
        PWM_CW     <= next_cw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RAMP;
      RAMP: if (frame_tick && !accept && (next_cw == eff)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RAMP);
  end

endmodule

// File: tb/tb_servo_cw_ramp.sv
// Directed self-checking bench for servo_cw_ramp, run with a short frame (PERIOD = 9) to keep runtime small.
module tb_servo_cw_ramp;

  localparam int PERIOD = 9;
  localparam int FRAME  = PERIOD + 1;

  logic        clk;
  logic        rst_n;
  logic [15:0] target_cw;
  logic        target_valid;
  logic        target_ready;
  logic [15:0] PWM_CW;
  logic        frame_tick;
  logic        busy;
  logic        clamp_hit;

  int testCount;
  int failCount;

  servo_cw_ramp #(
    .PERIOD (PERIOD),
    .STEP   (25),
    .INIT_CW(4688),
    .CW_MIN (3125),
    .CW_MAX (6250)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .target_cw   (target_cw),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .PWM_CW      (PWM_CW),
    .frame_tick  (frame_tick),
    .busy        (busy),
    .clamp_hit   (clamp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one target for a single cycle; it is accepted on the closing edge if ready.
  task automatic applyStimulus(input logic [15:0] cw);
    target_cw    = cw;
    target_valid = 1'b1;
    nextCycle();
    target_valid = 1'b0;
  endtask

  // Returns inside the cycle where frame_tick is high.
  task automatic waitTick(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      nextCycle();
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(found), 32'd1);
  endtask

  // Returns in the cycle after a tick, when PWM_CW has taken its new value.
  task automatic nextUpdate(input string tag);
    waitTick(tag);
    nextCycle();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int ticks;
    int expFinal;
    int expTicks;
    int expClamp;
    testCount    = 0;
    failCount    = 0;
    rst_n        = 1'b0;
    target_cw    = 16'd0;
    target_valid = 1'b0;

    nextCycle();
    nextCycle();
    checkOutput("rst_pwm_cw", 32'(PWM_CW), 32'd4688);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(target_ready), 32'd1);
    checkOutput("rst_tick", 32'(frame_tick), 32'd0);
    checkOutput("rst_clamp", 32'(clamp_hit), 32'd0);

    // First tick arrives FRAME edges after release, then every FRAME edges.
    rst_n = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      n = 0;
      for (int i = 1; i <= 3 * FRAME; i++) begin
        nextCycle();
        if (frame_tick) begin
          n = i;
          break;
        end
      end
      checkOutput(pass == 0 ? "first_tick_cycles" : "tick_period", 32'(n), 32'(FRAME));
    end
    checkOutput("idle_hold_cw", 32'(PWM_CW), 32'd4688);

    nextCycle();
    applyStimulus(16'd4788);
    checkOutput("up_busy_start", 32'(busy), 32'd1);
    checkOutput("up_ready_low", 32'(target_ready), 32'd0);
    nextUpdate("up_tick1");
    checkOutput("up_cw1", 32'(PWM_CW), 32'd4713);
    checkOutput("up_ready_back", 32'(target_ready), 32'd1);
    nextUpdate("up_tick2");
    checkOutput("up_cw2", 32'(PWM_CW), 32'd4738);
    nextUpdate("up_tick3");
    checkOutput("up_cw3", 32'(PWM_CW), 32'd4763);
    checkOutput("up_busy_mid", 32'(busy), 32'd1);
    nextUpdate("up_tick4");
    checkOutput("up_cw4", 32'(PWM_CW), 32'd4788);
    checkOutput("up_busy_end", 32'(busy), 32'd0);

    doReset();
    checkOutput("reset2_cw", 32'(PWM_CW), 32'd4688);
    applyStimulus(16'd4788);
    nextUpdate("redir_tick1");
    checkOutput("redir_cw1", 32'(PWM_CW), 32'd4713);
    nextUpdate("redir_tick2");
    checkOutput("redir_cw2", 32'(PWM_CW), 32'd4738);
    applyStimulus(16'd4700);
    nextUpdate("redir_tick3");
    checkOutput("redir_cw3", 32'(PWM_CW), 32'd4713);
    nextUpdate("redir_tick4");
    checkOutput("redir_cw4", 32'(PWM_CW), 32'd4700);
    checkOutput("redir_busy_end", 32'(busy), 32'd0);

    // Accept on the same edge that closes the tick cycle.
    doReset();
    waitTick("coll_wait");
    applyStimulus(16'd4600);
    checkOutput("coll_no_change", 32'(PWM_CW), 32'd4688);
    checkOutput("coll_busy", 32'(busy), 32'd1);
    checkOutput("coll_pending", 32'(target_ready), 32'd0);
    nextUpdate("coll_tick1");
    checkOutput("coll_cw1", 32'(PWM_CW), 32'd4663);
    nextUpdate("coll_tick2");
    checkOutput("coll_cw2", 32'(PWM_CW), 32'd4638);
    nextUpdate("coll_tick3");
    checkOutput("coll_cw3", 32'(PWM_CW), 32'd4613);
    nextUpdate("coll_tick4");
    checkOutput("coll_cw4_no_overshoot", 32'(PWM_CW), 32'd4600);
    checkOutput("coll_busy_end", 32'(busy), 32'd0);

    applyStimulus(16'd4650);
    target_cw    = 16'd4700;
    target_valid = 1'b1;
    checkOutput("bp_ready_low", 32'(target_ready), 32'd0);
    nextCycle();
    nextCycle();
    checkOutput("bp_still_low", 32'(target_ready), 32'd0);
    nextUpdate("bp_tick1");
    checkOutput("bp_cw1", 32'(PWM_CW), 32'd4625);
    checkOutput("bp_ready_back", 32'(target_ready), 32'd1);
    nextCycle();
    target_valid = 1'b0;
    checkOutput("bp_second_taken", 32'(target_ready), 32'd0);
    nextUpdate("bp_tick2");
    checkOutput("bp_cw2", 32'(PWM_CW), 32'd4650);
    nextUpdate("bp_tick3");
    checkOutput("bp_cw3", 32'(PWM_CW), 32'd4675);
    nextUpdate("bp_tick4");
    checkOutput("bp_cw4", 32'(PWM_CW), 32'd4700);
    checkOutput("bp_busy_end", 32'(busy), 32'd0);

`ifdef SERVO_CW_RAMP_CLAMP_EN
    expFinal = 6250;
    expTicks = 62;
    expClamp = 1;
`else
    expFinal = 7000;
    expTicks = 92;
    expClamp = 0;
`endif
    applyStimulus(16'd7000);
    checkOutput("clamp_pulse", 32'(clamp_hit), 32'(expClamp));
    nextCycle();
    checkOutput("clamp_pulse_end", 32'(clamp_hit), 32'd0);
    ticks = 0;
    while (busy && ticks < 200) begin
      nextUpdate("clamp_ramp_tick");
      ticks++;
    end
    checkOutput("clamp_ramp_ticks", 32'(ticks), 32'(expTicks));
    checkOutput("clamp_final_cw", 32'(PWM_CW), 32'(expFinal));

    applyStimulus(16'd5000);
    nextUpdate("midramp_tick");
    checkOutput("midramp_cw", 32'(PWM_CW), 32'(expFinal - 25));
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_cw", 32'(PWM_CW), 32'd4688);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_ready", 32'(target_ready), 32'd1);
    nextCycle();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/servo_cw_ramp.md
# servo_cw_ramp

Rate-limited command stage that produces the 16-bit compare word `PWM_CW` consumed by the PWM controller. It accepts target compare words from the processor side over a valid/ready handshake. It moves its output toward the target by at most `STEP` counts once per PWM frame, so the servo slews smoothly and the compare word never changes mid-frame more than once.

## Interface
Parameters:
- `PERIOD`, 62500: frame counter terminal value; the frame is `PERIOD+1` clk cycles, matching the PWM counter wrap.
- `STEP`, 25: maximum change of `PWM_CW` per frame; 0 means jump directly to the target.
- `INIT_CW`, 4688: reset value of the output and of the target.
- `CW_MIN`, 3125: lower clamp bound; used only with the clamp feature.
- `CW_MAX`, 6250: upper clamp bound; used only with the clamp feature.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `target_cw`, in, 16: requested compare word.
- `target_valid`, in, 1: `target_cw` is valid this cycle.
- `target_ready`, out, 1: the block can accept a target.
- `PWM_CW`, out, 16: registered compare word sent to the PWM controller.
- `frame_tick`, out, 1: one-cycle pulse at the end of each frame.
- `busy`, out, 1: a pending target exists or `PWM_CW` is not at the target.
- `clamp_hit`, out, 1: one-cycle pulse when an accepted target was clamped.

## Operation
- **Frame counter:** `frame_cnt` is 16 bits and counts 0..`PERIOD`, then wraps to 0. The registered `frame_tick` is 1 in the cycle after `frame_cnt == PERIOD`, i.e. the cycle `frame_cnt` reads 0.
- **Pending register:** holds one outstanding target. `target_ready = !pend_valid`, combinational.
  - Accept occurs when `target_valid && target_ready`; the block stores `target_cw` (clamped if enabled) and sets `pend_valid`.
  - While `pend_valid = 1`, `target_ready = 0`. A held `target_valid` is not accepted and the upstream must hold `target_cw` stable.
- **Effective target:** `eff = pend_valid ? pend : target_reg`.
- **On `frame_tick`:** the following updates happen together.
  - `target_reg <= eff`.
  - `pend_valid <= 0`.
  - `PWM_CW` steps toward `eff`.
- **Step arithmetic:** use a 17-bit unsigned difference; no wrap is possible.
  - If `eff > PWM_CW`: `PWM_CW <= (eff - PWM_CW > STEP) ? PWM_CW + STEP : eff`.
  - If `eff < PWM_CW`: mirror of the rule above.
  - If `eff == PWM_CW`: hold.
  - Result never overshoots `eff`.
  - If `STEP == 0`: `PWM_CW <= eff`.
- **FSM:** two states, IDLE and RAMP.
  - IDLE → RAMP on accept.
  - RAMP → IDLE on the tick where `PWM_CW` reaches `target_reg` and `pend_valid == 0`.
  - `busy = (state == RAMP)`.
- **Simultaneous accept and `frame_tick`:** the accept lands in pend. This tick uses the old `eff`, because `pend_valid` was 0 that cycle. The new target is applied at the next tick.
- **New target during a ramp:** the ramp redirects from the current `PWM_CW`. There is no restart from `INIT_CW`.
- **Reset (any time, including mid-ramp):**
  - `PWM_CW = INIT_CW`, `target_reg = INIT_CW`.
  - `pend_valid = 0`, `frame_cnt = 0`.
  - State IDLE.
  - A pending target is discarded.

## Timing
- Reset values of outputs:
  - `PWM_CW = INIT_CW`
  - `frame_tick = 0`
  - `target_ready = 1`
  - `busy = 0`
  - `clamp_hit = 0`
- `PWM_CW` changes only in the cycle after a `frame_tick`, at most once per `PERIOD+1` cycles.
- Accept to first `PWM_CW` change: the first `frame_tick` strictly after the accept cycle, plus 1 cycle (register update).
- Ramp length for distance D with `STEP > 0`: ceil(D/`STEP`) ticks.
- First `frame_tick` after reset release: `PERIOD+1` cycles after `frame_cnt` starts at 0.
- `target_ready` returns to 1 in the cycle after the consuming `frame_tick`.

## Configuration
- `SERVO_CW_RAMP_CLAMP_EN` defined:
  - An accepted `target_cw` is clamped to [`CW_MIN`, `CW_MAX`] before it is stored.
  - `clamp_hit` pulses 1 in the cycle after the accept whenever the stored value differs from `target_cw`.
- Not defined:
  - Targets are stored unmodified.
  - `CW_MIN` and `CW_MAX` are ignored.
  - `clamp_hit` is tied to 0.
  - The port is still present.

## Test plan
- **Reset:** `rst_n` low → `PWM_CW = 4688`, `busy = 0`, `target_ready = 1`. After release, `frame_tick` pulses every 62501 cycles.
- **Ramp up:** accept 4788 with `STEP = 25` → `PWM_CW` goes 4713, 4738, 4763, 4788 on 4 consecutive ticks. `busy` falls after the 4788 tick.
- **Tick collision:** accept 4600 in the same cycle as `frame_tick` → no change on that tick. First change to 4663 occurs on the next tick.
- **Redirect mid-ramp:** accept 4788, wait 2 ticks (`PWM_CW = 4738`), accept 4700 → next tick `PWM_CW = 4713`, then 4700.
- **Backpressure:** hold `target_valid` with `pend_valid = 1` → `target_ready = 0` until the tick, and the second value is accepted only after that.
- **Clamp:** with the macro, accept 7000 → stored 6250 and `clamp_hit` pulses once. Without the macro, the value is stored as 7000 and `clamp_hit` stays 0. Assert `rst_n` mid-ramp → `PWM_CW` returns to 4688 immediately.
